// File: rtl/atpg_comp_pkg.sv
// Shared types for the streaming ATPG compressor: fill modes, run FSM states
// and the reserved ESCAPE code.
package atpg_comp_pkg;

    typedef enum logic [1:0] {
        FILL_ZERO = 2'd0,
        FILL_ONE  = 2'd1,
        FILL_ADJ  = 2'd2,
        FILL_RSVD = 2'd3
    } fill_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2
    } run_state_e;

    // The code one past the last dictionary entry marks an unmatched pattern.
    function automatic int unsigned escape_code(input int unsigned dict_depth);
        return dict_depth;
    endfunction

endpackage

// File: rtl/atpg_dict_cam.sv
// Runtime-loadable dictionary with X-aware parallel compare. Lookup sees the
// contents as they were before any write in the same cycle.
module atpg_dict_cam
    import atpg_comp_pkg::*;
#(
    parameter int PAT_W      = 9,
    parameter int DICT_DEPTH = 8,
    parameter int CODE_W     = $clog2(DICT_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [CODE_W-1:0] wr_idx,
    input  logic [PAT_W-1:0]  wr_data,
    input  logic [PAT_W-1:0]  pattern,
    input  logic [PAT_W-1:0]  xmask,
    output logic              hit,
    output logic [CODE_W-1:0] code
);

    localparam int IDX_W = $clog2(DICT_DEPTH);

    logic [PAT_W-1:0]      entry_r [DICT_DEPTH];
    logic [DICT_DEPTH-1:0] valid_r;

    // Dictionary load; out-of-range indices are dropped, reset only clears valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= '0;
        end else if (wr_en && (wr_idx < CODE_W'(DICT_DEPTH))) begin
            valid_r[wr_idx[IDX_W-1:0]] <= 1'b1;
            entry_r[wr_idx[IDX_W-1:0]] <= wr_data;
        end
    end

    // Masked compare, scanned from the top so the lowest matching index wins
    always_comb begin
        hit  = 1'b0;
        code = CODE_W'(escape_code(DICT_DEPTH));
        for (int i = DICT_DEPTH - 1; i >= 0; i--) begin
            if (valid_r[i] && (((entry_r[i] ^ pattern) & ~xmask) == '0)) begin
                hit  = 1'b1;
                code = CODE_W'(i);
            end else begin
                hit  = hit;
                code = code;
            end
        end
    end

endmodule

// File: rtl/hybrid_atpg_compressor_stream.sv
// Streaming ATPG compressor: dictionary lookup, X-fill of misses and
// run-length merge of equal codes behind valid/ready handshakes.
module hybrid_atpg_compressor_stream
    import atpg_comp_pkg::*;
#(
    parameter int   PAT_W      = 9,
    parameter int   DICT_DEPTH = 8,
    parameter int   RUN_W      = 4,
    localparam int  CODE_W     = $clog2(DICT_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        fill_mode,
    input  logic              dict_wr_en,
    input  logic [CODE_W-1:0] dict_wr_idx,
    input  logic [PAT_W-1:0]  dict_wr_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PAT_W-1:0]  in_pattern,
    input  logic [PAT_W-1:0]  in_xmask,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [RUN_W-1:0]  out_run,
    output logic [PAT_W-1:0]  out_literal,
    output logic              out_last
);

    localparam logic [CODE_W-1:0] ESC     = CODE_W'(escape_code(DICT_DEPTH));
    localparam logic [RUN_W-1:0]  RUN_MAX = '1;
    localparam logic [RUN_W-1:0]  RUN_ONE = RUN_W'(1);

    // Replace X bits: constant 0/1, or copy the filled bit just below (bit 0 gets 0)
    function automatic logic [PAT_W-1:0] x_fill(input logic [PAT_W-1:0] pat,
                                               input logic [PAT_W-1:0] xm,
                                               input fill_mode_e       mode);
        logic [PAT_W-1:0] f;
        logic             prev;
        f    = '0;
        prev = 1'b0;
        for (int i = 0; i < PAT_W; i++) begin
            if (!xm[i]) begin
                f[i] = pat[i];
            end else begin
                case (mode)
                    FILL_ONE: f[i] = 1'b1;
                    FILL_ADJ: f[i] = prev;
                    default:  f[i] = 1'b0;
                endcase
            end
            prev = f[i];
        end
        return f;
    endfunction

    run_state_e        state_r, state_nx_s;
    logic [CODE_W-1:0] run_code_r, run_code_nx_s;
    logic [RUN_W-1:0]  run_cnt_r, run_cnt_nx_s;
    logic [PAT_W-1:0]  run_lit_r, run_lit_nx_s;

    logic              emit_s, emit_last_s;
    logic [CODE_W-1:0] emit_code_s;
    logic [RUN_W-1:0]  emit_run_s;
    logic [PAT_W-1:0]  emit_lit_s;

    logic              out_valid_r, out_last_r;
    logic [CODE_W-1:0] out_code_r;
    logic [RUN_W-1:0]  out_run_r;
    logic [PAT_W-1:0]  out_lit_r;

    logic              cam_hit_s, accept_s, out_free_s, merge_s;
    logic [CODE_W-1:0] cam_code_s, new_code_s;
    logic [PAT_W-1:0]  new_lit_s;

    atpg_dict_cam #(
        .PAT_W      (PAT_W),
        .DICT_DEPTH (DICT_DEPTH),
        .CODE_W     (CODE_W)
    ) u_cam (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (dict_wr_en),
        .wr_idx  (dict_wr_idx),
        .wr_data (dict_wr_data),
        .pattern (in_pattern),
        .xmask   (in_xmask),
        .hit     (cam_hit_s),
        .code    (cam_code_s)
    );

    assign out_free_s = !out_valid_r || out_ready;
    assign in_ready   = (state_r != ST_FLUSH) && out_free_s;
    assign accept_s   = in_valid && in_ready;
    assign new_code_s = cam_hit_s ? cam_code_s : ESC;
    assign new_lit_s  = cam_hit_s ? '0 : x_fill(in_pattern, in_xmask, fill_mode_e'(fill_mode));
    // Escapes never merge; a full run forces a new one
    assign merge_s    = (new_code_s == run_code_r) && (new_code_s != ESC) && (run_cnt_r != RUN_MAX);

    // Run FSM: decide what the accepted pattern does to the open run and what is emitted
    always_comb begin
        state_nx_s    = state_r;
        run_code_nx_s = run_code_r;
        run_cnt_nx_s  = run_cnt_r;
        run_lit_nx_s  = run_lit_r;
        emit_s        = 1'b0;
        emit_code_s   = run_code_r;
        emit_run_s    = run_cnt_r;
        emit_lit_s    = run_lit_r;
        emit_last_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && in_last) begin
                    emit_s      = 1'b1;
                    emit_code_s = new_code_s;
                    emit_run_s  = RUN_ONE;
                    emit_lit_s  = new_lit_s;
                    emit_last_s = 1'b1;
                end else if (accept_s) begin
                    state_nx_s    = ST_ACCUM;
                    run_code_nx_s = new_code_s;
                    run_cnt_nx_s  = RUN_ONE;
                    run_lit_nx_s  = new_lit_s;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s && merge_s) begin
                    if (in_last) begin
                        emit_s      = 1'b1;
                        emit_run_s  = run_cnt_r + RUN_ONE;
                        emit_last_s = 1'b1;
                        state_nx_s  = ST_IDLE;
                    end else begin
                        run_cnt_nx_s = run_cnt_r + RUN_ONE;
                    end
                end else if (accept_s) begin
                    emit_s        = 1'b1;
                    run_code_nx_s = new_code_s;
                    run_cnt_nx_s  = RUN_ONE;
                    run_lit_nx_s  = new_lit_s;
                    if (in_last) begin
                        state_nx_s = ST_FLUSH;
                    end else begin
                        state_nx_s = ST_ACCUM;
                    end
                end else begin
                    state_nx_s = ST_ACCUM;
                end
            end
            ST_FLUSH: begin
                if (out_free_s) begin
                    emit_s      = 1'b1;
                    emit_last_s = 1'b1;
                    state_nx_s  = ST_IDLE;
                end else begin
                    state_nx_s = ST_FLUSH;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and open-run registers; reset discards any open run
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            run_code_r <= '0;
            run_cnt_r  <= '0;
            run_lit_r  <= '0;
        end else begin
            state_r    <= state_nx_s;
            run_code_r <= run_code_nx_s;
            run_cnt_r  <= run_cnt_nx_s;
            run_lit_r  <= run_lit_nx_s;
        end
    end

    // Single output word: loaded on emit, held under backpressure, zeroed after handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_code_r  <= '0;
            out_run_r   <= '0;
            out_lit_r   <= '0;
            out_last_r  <= 1'b0;
        end else if (emit_s) begin
            out_valid_r <= 1'b1;
            out_code_r  <= emit_code_s;
            out_run_r   <= emit_run_s;
            out_lit_r   <= emit_lit_s;
            out_last_r  <= emit_last_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_code_r  <= '0;
            out_run_r   <= '0;
            out_lit_r   <= '0;
            out_last_r  <= 1'b0;
        end
    end

    assign out_valid   = out_valid_r;
    assign out_code    = out_code_r;
    assign out_run     = out_run_r;
    assign out_literal = out_lit_r;
    assign out_last    = out_last_r;

endmodule
